imem_loader: RTL and testbench

Boot-time writer for the byte-addressed instruction memory. Accepts a framed byte stream (sync, length, payload, XOR checksum) over a valid/ready interface and writes each payload byte to the memory's byte write port at consecutive addresses, so the core's little-endian fetch (`{b[PC+3], b[PC+2], b[PC+1], b[PC]}`) sees the loaded program. Holds the core in reset (`cpu_hold`) until a frame completes with a good checksum. Sits between the host serial receiver and the instruction memory write port.

---
 rtl/imem_loader_pkg.sv | 29 ++
 rtl/imem_loader.sv | 171 +++++++++++++++++
 tb/tb_imem_loader.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared constants and the state encoding of the instruction
//                memory boot loader.
//  Revision    : 1.0  initial release
// ============================================================================
package imem_loader_pkg;

    // First byte of every frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Width of the LEN field carried in the frame header.
    localparam int LEN_W = 16;

    // Loader states. The encoding is fixed so that it stays stable across
    // tools and is easy to read in waveforms.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } loader_state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time writer for the byte-addressed instruction memory.
//                Parses a framed byte stream (sync, LEN lo/hi, payload, XOR
//                checksum) and writes each payload byte to BASE+idx. Holds
//                the core in reset until a frame is loaded and verified.
//  Ports       : clk, rst_n              clock, synchronous active-low reset
//                rx_valid/rx_data/rx_ready   incoming byte stream
//                mem_we/mem_addr/mem_wdata/mem_ready  memory byte write port
//                cpu_hold                core reset request
//                load_done/load_err      result of the last frame
//  Revision    : 1.0  initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int BASE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    // One extra bit so that a count of 2^16 never wraps.
    localparam int c_CNT_W = LEN_W + 1;
    // Largest payload that still fits between BASE and the top of memory.
    localparam logic [c_CNT_W-1:0] c_MAX_LEN = c_CNT_W'((1 << ADDR_W) - BASE);

    loader_state_t        r_state;
    loader_state_t        w_state_next;
    logic [c_CNT_W-1:0]   r_len;
    logic [c_CNT_W-1:0]   r_idx;
    logic [7:0]           r_csum;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [7:0]           r_mem_wdata;

    logic                 w_rx_ready;
    logic                 w_accept;
    logic                 w_is_sync;
    logic [c_CNT_W-1:0]   w_len_full;
    logic [c_CNT_W-1:0]   w_idx_inc;

    // A byte can be taken whenever the write register is free or is being
    // emptied this cycle; nothing is accepted while reset is asserted.
    assign w_rx_ready = rst_n & (~r_mem_we | mem_ready);
    assign w_accept   = rx_valid & w_rx_ready;
    assign w_is_sync  = (rx_data == SYNC_BYTE);
    // Complete length as it will be once the high byte is latched.
    assign w_len_full = {1'b0, rx_data, r_len[7:0]};
    assign w_idx_inc  = r_idx + c_CNT_W'(1);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE, DONE, ERR: begin
                if (w_accept && w_is_sync) begin
                    w_state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                if (w_accept) begin
                    w_state_next = LEN_HI;
                end
            end
            LEN_HI: begin
                if (w_accept) begin
                    if ((w_len_full == '0) || (w_len_full > c_MAX_LEN)) begin
                        w_state_next = ERR;
                    end else begin
                        w_state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (w_accept && (w_idx_inc == r_len)) begin
                    w_state_next = CSUM;
                end
            end
            CSUM: begin
                // The checksum byte is only accepted when the write register
                // frees up on the same edge, so DONE never has a write pending.
                if (w_accept) begin
                    w_state_next = (rx_data == r_csum) ? DONE : ERR;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Length, index, running checksum and write-port registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_len       <= '0;
            r_idx       <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            if (w_accept) begin
                case (r_state)
                    IDLE, DONE, ERR: begin
                        if (w_is_sync) begin
                            r_idx  <= '0;
                            r_csum <= '0;
                        end
                    end
                    LEN_LO: r_len <= c_CNT_W'(rx_data);
                    LEN_HI: r_len <= w_len_full;
                    DATA: begin
                        r_idx  <= w_idx_inc;
                        r_csum <= r_csum ^ rx_data;
                    end
                    default: ;
                endcase
            end

            // A new payload byte reloads the write register even when the
            // previous write completes on this edge, giving back-to-back
            // writes without a bubble.
            if (w_accept && (r_state == DATA)) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= ADDR_W'(BASE) + r_idx[ADDR_W-1:0];
                r_mem_wdata <= rx_data;
            end else if (r_mem_we && mem_ready) begin
                r_mem_we    <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rx_ready  = w_rx_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_hold  = (r_state != DONE);
    assign load_done = (r_state == DONE);
    assign load_err  = (r_state == ERR);

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Self-checking bench for imem_loader (ADDR_W=8, BASE=0).
//                Expected memory writes are queued as bytes are sent and
//                matched against the write port as it handshakes.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ready;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    int checks   = 0;
    int failures = 0;
    int wr_seen  = 0;
    int wr_mark;

    logic [15:0] r_exp_q[$];          // {addr, data} per expected write
    logic [7:0]  r_mem_model [0:255];
    logic [7:0]  r_payload   [0:511];
    bit          r_bp_mode = 1'b0;

    imem_loader #(.ADDR_W(8), .BASE(0)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .cpu_hold  (cpu_hold),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory-side ready: in backpressure mode every second new write is
    // stalled for three cycles.
    initial begin : p_mem_ready
        bit we_prev = 1'b0;
        bit hs_prev = 1'b0;
        int wr_cnt  = 0;
        int stall   = 0;
        mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && mem_we && (!we_prev || hs_prev)) begin
                wr_cnt++;
                if (r_bp_mode && (wr_cnt % 2 == 0)) stall = 3;
            end
            if (stall > 0) begin
                mem_ready = 1'b0;
                stall--;
            end else begin
                mem_ready = 1'b1;
            end
            we_prev = mem_we;
            hs_prev = mem_we && mem_ready;
        end
    end

    // Write-port monitor: scoreboard compare, ready rule and stall stability.
    initial begin : p_monitor
        bit         stalled = 1'b0;
        logic [7:0] hold_addr = '0;
        logic [7:0] hold_data = '0;
        logic [15:0] exp_w;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                check("rx_ready_in_reset", rx_ready, 1'b0);
                stalled = 1'b0;
            end else begin
                check("rx_ready_rule", rx_ready, (!mem_we || mem_ready));
                if (stalled) begin
                    check("stall_addr_stable", mem_addr, hold_addr);
                    check("stall_data_stable", mem_wdata, hold_data);
                end
                if (mem_we && mem_ready) begin
                    wr_seen++;
                    r_mem_model[mem_addr] = mem_wdata;
                    if (r_exp_q.size() == 0) begin
                        check("unexpected_write", {mem_addr, mem_wdata}, 16'h0);
                        checks--;
                        failures += (({mem_addr, mem_wdata} === 16'h0) ? 1 : 0);
                    end else begin
                        exp_w = r_exp_q.pop_front();
                        check("write_addr_data", {mem_addr, mem_wdata}, exp_w);
                    end
                end
                stalled   = mem_we && !mem_ready;
                hold_addr = mem_addr;
                hold_data = mem_wdata;
            end
        end
    end

    // Present one byte and wait (bounded) for it to be accepted.
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        rx_valid = 1'b1;
        rx_data  = b;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (rx_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        rx_valid = 1'b0;
        if (!done) check("send_timeout", 1'b0, 1'b1);
    endtask

    // Payload and checksum of a frame whose header has already been sent.
    task automatic send_body(input int len, input logic [7:0] csum_flip, input int stop_after);
        logic [7:0] x = '0;
        for (int i = 0; i < len && i < stop_after; i++) begin
            r_exp_q.push_back({i[7:0], r_payload[i]});
            x ^= r_payload[i];
            send_byte(r_payload[i]);
        end
        if (stop_after >= len) send_byte(x ^ csum_flip);
    endtask

    task automatic send_frame(input int len, input logic [7:0] csum_flip);
        logic [15:0] l = len[15:0];
        send_byte(8'hA5);
        send_byte(l[7:0]);
        send_byte(l[15:8]);
        send_body(len, csum_flip, len);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"},   mem_we, 1'b0);
        check({tag, "_addr"}, mem_addr, 8'h00);
        check({tag, "_data"}, mem_wdata, 8'h00);
        check({tag, "_hold"}, cpu_hold, 1'b1);
        check({tag, "_done"}, load_done, 1'b0);
        check({tag, "_err"},  load_err, 1'b0);
        check({tag, "_rdy"},  rx_ready, 1'b0);
    endtask

    initial begin : p_stim
        logic [7:0] prog [0:19];
        logic [31:0] word0;
        prog = '{8'hB3, 8'h81, 8'h40, 8'h00, 8'hB3, 8'h81, 8'h11, 8'h40, 8'h23, 8'h28,
                 8'h10, 8'h00, 8'h83, 8'h21, 8'h00, 8'h01, 8'hA3, 8'h28, 8'h30, 8'h00};
        for (int i = 0; i < 256; i++) r_mem_model[i] = 8'hXX;
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Garbage before sync is swallowed without writes.
        wr_mark = wr_seen;
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        repeat (2) @(posedge clk);
        #1;
        check("garbage_no_writes", wr_seen - wr_mark, 0);
        check("garbage_hold", cpu_hold, 1'b1);

        // Program load.
        for (int i = 0; i < 20; i++) r_payload[i] = prog[i];
        wr_mark = wr_seen;
        send_frame(20, 8'h00);
        check("prog_done", load_done, 1'b1);
        check("prog_hold", cpu_hold, 1'b0);
        check("prog_err", load_err, 1'b0);
        check("prog_writes", wr_seen - wr_mark, 20);
        word0 = {r_mem_model[3], r_mem_model[2], r_mem_model[1], r_mem_model[0]};
        check("fetch_word0", word0, 32'h004081B3);

        // Sync in DONE re-asserts hold next cycle; frame continues with bad CSUM.
        send_byte(8'hA5);
        check("resync_hold", cpu_hold, 1'b1);
        check("resync_done_drop", load_done, 1'b0);
        wr_mark = wr_seen;
        send_byte(8'd20);
        send_byte(8'd0);
        send_body(20, 8'h01, 20);
        check("badcsum_err", load_err, 1'b1);
        check("badcsum_hold", cpu_hold, 1'b1);
        check("badcsum_writes", wr_seen - wr_mark, 20);

        // Good frame after an error.
        send_frame(20, 8'h00);
        check("recover_done", load_done, 1'b1);
        check("recover_err", load_err, 1'b0);

        // LEN = 0.
        wr_mark = wr_seen;
        send_byte(8'hA5);
        send_byte(8'h00);
        send_byte(8'h00);
        check("len0_err", load_err, 1'b1);
        check("len0_hold", cpu_hold, 1'b1);

        // LEN = 257 exceeds 256-byte memory.
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h01);
        check("len257_err", load_err, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("bad_len_no_writes", wr_seen - wr_mark, 0);

        // LEN = 256 under backpressure.
        for (int i = 0; i < 256; i++) r_payload[i] = 8'($urandom);
        r_bp_mode = 1'b1;
        wr_mark = wr_seen;
        send_frame(256, 8'h00);
        check("len256_done", load_done, 1'b1);
        check("len256_writes", wr_seen - wr_mark, 256);
        check("len256_last", r_mem_model[255], r_payload[255]);
        r_bp_mode = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // Reset after the fifth payload byte.
        for (int i = 0; i < 20; i++) r_payload[i] = 8'(8'h30 + i * 7);
        send_byte(8'hA5);
        send_byte(8'd20);
        send_byte(8'd0);
        send_body(20, 8'h00, 5);
        rst_n = 1'b0;
        void'(r_exp_q.pop_back());   // the pending fifth write is dropped
        @(posedge clk);
        #1;
        check_idle_outputs("midreset");
        rst_n = 1'b1;
        send_frame(20, 8'h00);
        check("after_reset_done", load_done, 1'b1);
        check("after_reset_byte4", r_mem_model[4], r_payload[4]);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", r_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
